z1010_ff_cfg_loader: RTL and testbench

Configuration sequencer for the z1010 logic-cluster flop slots. Accepts one mode word per flop slot over a valid/ready stream and checks each word against the flop variants the architecture provides (dff, dffe, dffr, dffs, dffh, dffl, dffer, dffes, dffeh, dffel, with their polarity options). Legal words are shifted LSB-first into the cluster's serial configuration chain; a single latch pulse then commits the whole chain. Sits between the bitstream front end and one cluster's flop configuration shift register.

---
 rtl/z1010_ff_cfg_loader.sv | 143 ++++++++++++++
 tb/tb_z1010_ff_cfg_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/z1010_ff_cfg_loader.sv
// Flop-slot configuration sequencer for one z1010 logic cluster.
// Checks each mode word, shifts legal words LSB-first, commits with a latch pulse.
module z1010_ff_cfg_loader #(
  parameter int NUM_FF = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [6:0] cfg_data,
  output logic       sdo,
  output logic       sen,
  output logic       latch,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [5:0] err_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_SHIFT,
    S_ERR
  } state_e;

  localparam logic [6:0] LAST_SLOT = 7'(NUM_FF - 1);

  state_e     state_q, state_d;
  logic [6:0] slot_q, slot_d;
  logic [6:0] word_q, word_d;
  logic [2:0] bit_q, bit_d;
  logic       latch_q, latch_d;
  logic       error_q, error_d;
  logic [5:0] err_idx_q, err_idx_d;

  logic [3:0] ty;
  logic       cinv, einv, rinv;
  logic       legal;

  assign ty   = cfg_data[3:0];
  assign cinv = cfg_data[4];
  assign einv = cfg_data[5];
  assign rinv = cfg_data[6];

  always_comb begin
    legal = 1'b1;
    if (ty > 4'd9)
      legal = 1'b0;
    if (cinv && !(ty inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7}))
      legal = 1'b0;
    if (einv && !(ty inside {4'd1, 4'd6, 4'd7, 4'd8, 4'd9}))
      legal = 1'b0;
    if (rinv && (ty < 4'd2))
      legal = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    word_d    = word_q;
    bit_d     = bit_q;
    latch_d   = 1'b0;
    error_d   = error_q;
    err_idx_d = err_idx_q;
    unique case (state_q)
      S_IDLE: begin
        // the commit cycle still counts as busy
        if (start && !latch_q) begin
          state_d = S_RECV;
          slot_d  = '0;
        end
      end
      S_RECV: begin
        if (cfg_valid) begin
          if (legal) begin
            state_d = S_SHIFT;
            word_d  = cfg_data;
            bit_d   = '0;
          end else begin
            state_d   = S_ERR;
            error_d   = 1'b1;
            err_idx_d = slot_q[5:0];
          end
        end
      end
      S_SHIFT: begin
        if (bit_q == 3'd6) begin
          if (slot_q == LAST_SLOT) begin
            state_d = S_IDLE;
            latch_d = 1'b1;
            slot_d  = '0;
          end else begin
            state_d = S_RECV;
            slot_d  = slot_q + 7'd1;
          end
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      S_ERR: begin
        if (start) begin
          state_d   = S_RECV;
          slot_d    = '0;
          error_d   = 1'b0;
          err_idx_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      slot_q    <= '0;
      word_q    <= '0;
      bit_q     <= '0;
      latch_q   <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      word_q    <= word_d;
      bit_q     <= bit_d;
      latch_q   <= latch_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign cfg_ready = (state_q == S_RECV);
  assign sen       = (state_q == S_SHIFT);
  assign sdo       = sen & word_q[bit_q];
  assign latch     = latch_q;
  assign done      = latch_q;
  assign busy      = (state_q == S_RECV) | (state_q == S_SHIFT) | latch_q;
  assign error     = error_q;
  assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_z1010_ff_cfg_loader.sv
// Directed bench for z1010_ff_cfg_loader: a 2-slot and a 4-slot instance
// share the word stream; each has its own start.
module tb_z1010_ff_cfg_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [6:0] cfg_data = '0;
  logic [1:0] start = '0;
  logic [1:0] rdy, sdo, sen, lat, busy, done, err;
  logic [5:0] eidx [2];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  int          nsen [2];
  int          nlat [2];
  int          ndone [2];
  int          novl [2];
  int          lat_cyc [2];
  int          st_cyc [2];
  logic        busy_at_lat [2];
  logic        busy_after [2];
  logic        lat_prev [2];
  logic [63:0] stream [2];

  z1010_ff_cfg_loader #(.NUM_FF(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start[0]),
    .cfg_valid(cfg_valid), .cfg_ready(rdy[0]), .cfg_data(cfg_data),
    .sdo(sdo[0]), .sen(sen[0]), .latch(lat[0]), .busy(busy[0]),
    .done(done[0]), .error(err[0]), .err_idx(eidx[0])
  );

  z1010_ff_cfg_loader #(.NUM_FF(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start[1]),
    .cfg_valid(cfg_valid), .cfg_ready(rdy[1]), .cfg_data(cfg_data),
    .sdo(sdo[1]), .sen(sen[1]), .latch(lat[1]), .busy(busy[1]),
    .done(done[1]), .error(err[1]), .err_idx(eidx[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (sen[d]) begin
        if (nsen[d] < 64) stream[d][nsen[d]] = sdo[d];
        nsen[d]++;
      end
      if (sen[d] && rdy[d]) novl[d]++;
      if (done[d]) ndone[d]++;
      if (lat_prev[d]) busy_after[d] = busy[d];
      if (lat[d]) begin
        nlat[d]++;
        lat_cyc[d] = cyc;
        busy_at_lat[d] = busy[d];
      end
      lat_prev[d] = lat[d];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr(input int d);
    nsen[d] = 0;
    nlat[d] = 0;
    ndone[d] = 0;
    novl[d] = 0;
    lat_cyc[d] = 0;
    stream[d] = '0;
    busy_at_lat[d] = 1'b0;
    busy_after[d] = 1'b1;
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    st_cyc[d] = cyc;
    tick();
    start[d] = 1'b0;
  endtask

  task automatic send(input int d, input logic [6:0] w, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      cfg_valid = 1'b0;
      tick();
    end
    cfg_valid = 1'b1;
    cfg_data = w;
    n = 0;
    while (!rdy[d] && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("send_timeout", 64'(n), 64'd0);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [63:0] outs(input int d);
    return 64'({rdy[d], sdo[d], sen[d], lat[d], busy[d],
                done[d], err[d], eidx[d]});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr(0);
    clr(1);
    lat_prev[0] = 1'b0;
    lat_prev[1] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_outs2", outs(0), 64'd0);
    chk("reset_outs4", outs(1), 64'd0);

    // two legal words back to back on the 2-slot instance
    clr(0);
    pulse_start(0);
    chk("ready_after_start", 64'(rdy[0]), 64'd1);
    send(0, 7'h01, 0);
    send(0, 7'h12, 0);
    idle(12);
    chk("b2b_nsen", 64'(nsen[0]), 64'd14);
    chk("b2b_stream", stream[0], 64'h0901);
    chk("b2b_nlat", 64'(nlat[0]), 64'd1);
    chk("b2b_ndone", 64'(ndone[0]), 64'd1);
    chk("b2b_latency", 64'(lat_cyc[0] - st_cyc[0]), 64'd17);
    chk("b2b_busy_at_lat", 64'(busy_at_lat[0]), 64'd1);
    chk("b2b_busy_after", 64'(busy_after[0]), 64'd0);
    chk("b2b_ovl", 64'(novl[0]), 64'd0);
    chk("b2b_err", 64'(err[0]), 64'd0);

    // illegal type on the third slot of the 4-slot instance
    clr(1);
    pulse_start(1);
    send(1, 7'h01, 0);
    send(1, 7'h12, 0);
    send(1, 7'h0A, 0);
    chk("bad_type_err", 64'(err[1]), 64'd1);
    chk("bad_type_idx", 64'(eidx[1]), 64'd2);
    chk("bad_type_busy", 64'(busy[1]), 64'd0);
    idle(10);
    chk("bad_type_nsen", 64'(nsen[1]), 64'd14);
    chk("bad_type_sticky", 64'(err[1]), 64'd1);
    pulse_start(1);
    chk("restart_err", 64'(err[1]), 64'd0);
    chk("restart_idx", 64'(eidx[1]), 64'd0);
    chk("restart_ready", 64'(rdy[1]), 64'd1);

    // illegal polarity options, one session each
    send(1, 7'h13, 0);
    chk("cinv_dffs_err", 64'(err[1]), 64'd1);
    chk("cinv_dffs_idx", 64'(eidx[1]), 64'd0);
    pulse_start(1);
    send(1, 7'h00, 0);
    send(1, 7'h22, 0);
    chk("einv_dffr_err", 64'(err[1]), 64'd1);
    chk("einv_dffr_idx", 64'(eidx[1]), 64'd1);
    pulse_start(1);
    send(1, 7'h41, 0);
    chk("rinv_dffe_err", 64'(err[1]), 64'd1);
    chk("rinv_dffe_idx", 64'(eidx[1]), 64'd0);
    chk("err_sessions_nlat", 64'(nlat[1]), 64'd0);

    // same words with gaps in cfg_valid
    clr(0);
    pulse_start(0);
    send(0, 7'h01, int'($urandom_range(1, 5)));
    send(0, 7'h12, int'($urandom_range(1, 5)));
    idle(12);
    chk("gap_stream", stream[0], 64'h0901);
    chk("gap_nsen", 64'(nsen[0]), 64'd14);
    chk("gap_nlat", 64'(nlat[0]), 64'd1);
    chk("gap_ovl", 64'(novl[0]), 64'd0);

    // reset on the fourth shift cycle
    clr(1);
    pulse_start(1);
    send(1, 7'h46, 0);
    idle(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_outs", outs(1), 64'd0);
    chk("mid_rst_nsen", 64'(nsen[1]), 64'd4);
    chk("mid_rst_bits", stream[1], 64'h6);
    idle(10);
    chk("mid_rst_nlat", 64'(nlat[1]), 64'd0);

    // clean 4-slot session with a stray start during SHIFT
    clr(1);
    pulse_start(1);
    send(1, 7'h00, 0);
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    send(1, 7'h01, 0);
    send(1, 7'h46, 0);
    send(1, 7'h28, 0);
    idle(12);
    chk("full_stream", stream[1], 64'h5118080);
    chk("full_nsen", 64'(nsen[1]), 64'd28);
    chk("full_nlat", 64'(nlat[1]), 64'd1);
    chk("full_ndone", 64'(ndone[1]), 64'd1);
    chk("full_latency", 64'(lat_cyc[1] - st_cyc[1]), 64'd33);
    chk("full_err", 64'(err[1]), 64'd0);
    chk("full_ovl", 64'(novl[1]), 64'd0);
    chk("full_busy_end", 64'(busy[1]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
